mul_operand_sequencer: RTL and testbench

MUL_OPERAND_SEQUENCER -- requirements
Module: mul_operand_sequencer

---
 rtl/mul_operand_sequencer.sv | 121 ++++++++++++
 tb/tb_mul_operand_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer.sv
// Operand sequencer for a repeated-addition multiplier.
// Operand pairs are queued in a small FIFO. For each pair the block issues
// a one-cycle start, then places A and then B on the shared data bus, and
// waits for the multiplier's done. The head pair stays queued until its
// job finishes.
module mul_operand_sequencer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    output logic                     in_ready,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_data,
    input  logic                     mul_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               completed
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND_A,
        SEND_B,
        WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic             push;
    logic             pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    // Ready comes from the registered count only, so a pop cannot free a slot
    // for a push in the same cycle.
    assign in_ready = (count < FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == WAIT) && mul_done;
    assign busy     = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a done left high from the previous job holds us in IDLE.
    always_comb begin
        // NOTE: default first so that every path assigns state_next and no latch
        // is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (count != '0 && !mul_done) state_next = START;
            START:   state_next = SEND_A;
            SEND_A:  state_next = SEND_B;
            SEND_B:  state_next = WAIT;
            WAIT:    if (mul_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        mul_start = 1'b0;
        mul_data  = '0;
        unique case (state)
            START:   mul_start = 1'b1;
            SEND_A:  mul_data  = mem_a[rd_ptr];
            SEND_B:  mul_data  = mem_b[rd_ptr];
            default: ;
        endcase
    end

    // FIFO bookkeeping and the completed-job counter (wraps naturally at 8 bits).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            completed <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop) begin
                rd_ptr    <= next_ptr(rd_ptr);
                completed <= completed + 8'd1;
            end
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Operand storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; entries are only read
        // after being written, and count/pointers alone define what is valid.
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Self-checking bench for mul_operand_sequencer: a queue-based model predicts
// every output on every cycle, and directed scenarios pin literal values.
module tb_mul_operand_sequencer;

    localparam int W = 16;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_ready;
    logic           mul_start;
    logic [W-1:0]   mul_data;
    logic           mul_done = 1'b0;
    logic           busy;
    logic [$clog2(D):0] count;
    logic [7:0]     completed;

    mul_operand_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ready  (in_ready),
        .mul_start (mul_start),
        .mul_data  (mul_data),
        .mul_done  (mul_done),
        .busy      (busy),
        .count     (count),
        .completed (completed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued pairs, job age in cycles since start (-1 = no job).
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    pair_t q[$];
    int    m_phase = -1;
    int    m_comp  = 0;
    bit    m_pop;
    bit    m_push;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_phase = -1;
            m_comp  = 0;
        end else begin
            m_pop  = (m_phase >= 3) && mul_done;
            m_push = in_valid && (q.size() < D);
            if (m_phase < 0) begin
                if (q.size() > 0 && !mul_done) m_phase = 0;
            end else if (m_phase < 3) begin
                m_phase++;
            end else if (mul_done) begin
                m_phase = -1;
            end
            if (m_pop) begin
                void'(q.pop_front());
                m_comp = (m_comp + 1) % 256;
            end
            if (m_push) q.push_back('{in_a, in_b});
        end
    end

    // Compare every output against the model, away from the active edge.
    logic [W-1:0] exp_data;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_data = '0;
            if (m_phase == 1) exp_data = q[0].a;
            if (m_phase == 2) exp_data = q[0].b;
            check("m_count",     32'(count),     32'(q.size()));
            check("m_in_ready",  32'(in_ready),  32'(q.size() < D));
            check("m_completed", 32'(completed), 32'(m_comp));
            check("m_busy",      32'(busy),      32'(m_phase >= 0));
            check("m_start",     32'(mul_start), 32'(m_phase == 0));
            check("m_data",      32'(mul_data),  32'(exp_data));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    // Wait (bounded) until the model says the job is in its waiting phase.
    task automatic wait_for_wait();
        int n = 0;
        while (m_phase < 3 && n < 20) begin
            cyc();
            n++;
        end
        check("wait_timeout", 32'(m_phase >= 3), 32'd1);
    endtask

    task automatic finish_job();
        wait_for_wait();
        mul_done = 1'b1;
        cyc();
        mul_done = 1'b0;
    endtask

    initial begin
        // Reset
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        check("rst_start", 32'(mul_start), 32'd0);
        check("rst_data",  32'(mul_data),  32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        check("rst_count", 32'(count),     32'd0);

        // Single job (100,17)
        in_valid = 1'b1; in_a = 16'd100; in_b = 16'd17;
        cyc();
        in_valid = 1'b0;
        check("single_count1", 32'(count), 32'd1);
        check("single_nostart", 32'(mul_start), 32'd0);
        cyc();
        check("single_start", 32'(mul_start), 32'd1);
        check("single_d0",    32'(mul_data),  32'd0);
        check("single_busy",  32'(busy),      32'd1);
        cyc();
        check("single_a",     32'(mul_data),  32'd100);
        check("single_start_low", 32'(mul_start), 32'd0);
        cyc();
        check("single_b",     32'(mul_data),  32'd17);
        cyc();
        check("single_wait_d", 32'(mul_data), 32'd0);
        check("single_wait_busy", 32'(busy), 32'd1);
        mul_done = 1'b1;
        cyc();
        mul_done = 1'b0;
        check("single_completed", 32'(completed), 32'd1);
        check("single_count0",    32'(count),     32'd0);
        check("single_idle",      32'(busy),      32'd0);

        // Fill: five back-to-back offers, the fifth is refused
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = W'(11 + i); in_b = W'(21 + i);
            cyc();
            check("fill_count", 32'(count), (i + 1 < 4) ? 32'(i + 1) : 32'd4);
            check("fill_ready", 32'(in_ready), 32'(i + 1 < 4));
        end
        in_valid = 1'b0;
        mul_done = 1'b1;
        cyc();
        mul_done = 1'b0;
        check("fill_pop_count", 32'(count),    32'd3);
        check("fill_pop_ready", 32'(in_ready), 32'd1);
        cyc();
        cyc();
        check("fill_next_a", 32'(mul_data), 32'd12);
        for (int i = 0; i < 3; i++) finish_job();
        check("fill_drained", 32'(count), 32'd0);
        check("fill_completed", 32'(completed), 32'd5);

        // Simultaneous push and pop with two entries queued
        in_valid = 1'b1; in_a = 16'd201; in_b = 16'd1;
        cyc();
        in_a = 16'd202; in_b = 16'd2;
        cyc();
        in_valid = 1'b0;
        wait_for_wait();
        in_valid = 1'b1; in_a = 16'd203; in_b = 16'd3;
        mul_done = 1'b1;
        cyc();
        in_valid = 1'b0; mul_done = 1'b0;
        check("simul_count", 32'(count), 32'd2);
        check("simul_completed", 32'(completed), 32'd6);
        cyc();
        check("simul_start", 32'(mul_start), 32'd1);
        cyc();
        check("simul_old_second", 32'(mul_data), 32'd202);

        // Sticky done holds the FSM in IDLE
        wait_for_wait();
        mul_done = 1'b1;
        cyc();
        check("sticky_completed", 32'(completed), 32'd7);
        check("sticky_count", 32'(count), 32'd1);
        cyc();
        cyc();
        check("sticky_idle",    32'(busy),      32'd0);
        check("sticky_nostart", 32'(mul_start), 32'd0);
        mul_done = 1'b0;
        cyc();
        check("sticky_start", 32'(mul_start), 32'd1);

        // Reset in the middle of a job
        cyc();
        check("midrst_a", 32'(mul_data), 32'd203);
        cyc();
        check("midrst_b", 32'(mul_data), 32'd3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midrst_data",  32'(mul_data),  32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_count", 32'(count),     32'd0);
        check("midrst_comp",  32'(completed), 32'd0);
        check("midrst_ready", 32'(in_ready),  32'd1);

        // 257 single jobs: completed wraps and pointers wrap many times
        for (int k = 1; k <= 257; k++) begin
            in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
            cyc();
            in_valid = 1'b0;
            finish_job();
            if (k == 255) check("wrap_255", 32'(completed), 32'd255);
            if (k == 256) check("wrap_0",   32'(completed), 32'd0);
            if (k == 257) check("wrap_1",   32'(completed), 32'd1);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            mul_done = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 1'b0; in_valid = 1'b0; mul_done = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
